load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 16, meaning bus-wait cycles before a timeout error (range 1..255).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port mem_en  input  1  core requests a load/store this instruction.
REQ-005 SHALL have port mem_we  input  1  1 = store, 0 = load.
REQ-006 SHALL have port funct3  input  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 SHALL have port addr  input  32  byte address (ALU result).
REQ-008 SHALL have port wdata  input  32  store data (rs2).
REQ-009 SHALL have port rdata  output  32  extended load data to the core's result mux.
REQ-010 SHALL have port stall  output  1  freeze PC/register write while high.
REQ-011 SHALL have port err  output  1  one-cycle access-fault pulse.
REQ-012 SHALL have ports bus_req/bus_we  output  1 each, and bus_addr/bus_wdata  output  32 each, plus bus_be  output  4.
REQ-013 SHALL have ports bus_ack  input  1  and bus_rdata  input  32.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, DONE.
- IDLE: on mem_en=1 (and no trap per REQ-026), latch request and go to ACCESS.
- ACCESS: on bus_ack=1 or timeout, go to DONE.
- DONE: unconditionally return to IDLE after one cycle.
REQ-015 SHALL drive stall = (IDLE & mem_en & ~trap) | ACCESS; stall SHALL be 0 in DONE.
REQ-016 SHALL assert bus_req only in ACCESS, held constant with bus_addr/bus_we/bus_wdata/bus_be until bus_ack.
REQ-017 SHALL drive bus_addr = {addr[31:2], 2'b00} as latched.
REQ-018 SHALL drive bus_be as follows: byte 0001<<addr[1:0]; half 0011<<{addr[1],1'b0}; word 1111. It SHALL apply to both loads and stores.
REQ-019 SHALL replicate store data on the bus: byte into all four lanes, half into both halves, word unchanged.
REQ-020 SHALL capture bus_rdata on the ack cycle, select the lane by addr, and zero-extend (BU/HU) or sign-extend (B/H) it; rdata SHALL hold this value through DONE.
REQ-021 SHALL give stores rdata = 0.
REQ-022 SHALL treat funct3 values 011/110/111 as word.
REQ-023 SHALL give minimum latency of 2 stall cycles: request cycle plus one ACCESS cycle with ack; each extra non-ack cycle adds one.
REQ-024 SHALL count wait cycles in ACCESS from 1; on reaching MAX_WAIT without ack, it SHALL deassert bus_req, pulse err in DONE, and set rdata = 0.
REQ-025 SHALL give bus_ack priority over timeout when both occur in the same cycle (no err).
REQ-026 SHALL ignore mem_en in DONE and ACCESS; a new request is sampled only in IDLE.

Reset
REQ-027 SHALL, while reset=0, asynchronously force state IDLE, wait counter 0, and rdata, bus_addr, bus_wdata, bus_be, bus_req, bus_we, err, and latched request all to 0.
REQ-028 SHALL abandon an in-flight access on reset assertion mid-ACCESS: bus_req drops immediately and no err is raised.
REQ-029 SHALL make the first request sampling possible on the first rising edge after reset deasserts.

Configuration
REQ-030 SHALL support macro LSU_MISALIGN_TRAP_EN.
- Defined: misaligned H/HU/SH (addr[0]=1) or W/SW (addr[1:0]!=0) SHALL start no bus transaction, pulse err for the request cycle, keep stall=0, and force rdata=0.
- Undefined: the unit SHALL ignore the offending low address bits (half uses addr[1], word forced aligned) and perform the access normally, with err never asserted for alignment.

Verification
REQ-031 SHALL cover: LW addr 0x100, bus_rdata 0xDEADBEEF, ack in 1st ACCESS cycle -> bus_be=1111, rdata=0xDEADBEEF, stall high exactly 2 cycles.
REQ-032 SHALL cover: LB addr 0x103, bus_rdata 0x80FF_FFFF -> bus_be=1000, rdata=0xFFFFFF80; repeated with LBU -> rdata=0x00000080.
REQ-033 SHALL cover: SH addr 0x202, wdata 0x1234ABCD, ack after 3 wait cycles -> bus_be=1100, bus_wdata=0xABCDABCD, bus_we=1, stall high 4 cycles.
REQ-034 SHALL cover: LW with bus_ack held 0, MAX_WAIT=16 -> bus_req high 16 cycles, err pulses once, rdata=0, stall releases.
REQ-035 SHALL cover: LW addr 0x101 -> with LSU_MISALIGN_TRAP_EN, err=1, bus_req never asserted; without it, bus_addr=0x100, bus_be=1111, no err.
REQ-036 SHALL cover: reset=0 asserted during the 2nd ACCESS cycle -> bus_req and stall drop the same cycle, state IDLE, no err.

Source files
------------

// File: rtl/load_store_unit_if.sv
// load_store_unit_if -- memory-bus side of the load/store unit.
// The master modport belongs to the unit; the slave modport to the memory/bus model.
interface load_store_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit -- single-outstanding load/store unit between a core and a
// request/acknowledge memory bus. Sub-word stores are lane-replicated; loads
// are lane-selected and sign/zero-extended. A wait counter aborts an access
// that is not acknowledged within MAX_WAIT cycles and pulses err.
// Optional feature: define LSU_MISALIGN_TRAP_EN to fault misaligned half/word
// accesses instead of silently aligning them.
module load_store_unit #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        err,
  load_store_unit_if.master mem
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  // Access size codes kept in the latched request.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t      state_q;
  logic [7:0]  wait_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic [3:0]  bus_be_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        req_we_q;
  logic [1:0]  req_size_q;
  logic        req_uns_q;
  logic [1:0]  req_off_q;

  logic        is_byte;
  logic        is_half;
  logic [1:0]  size_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic        trap;
  logic        in_idle;
  logic        in_access;

  // Lane select plus extension of the acknowledged bus word.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic        uns,
                                              input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    if (size == SZ_BYTE) begin
      r = uns ? {24'd0, b} : {{24{b[7]}}, b};
    end else if (size == SZ_HALF) begin
      r = uns ? {16'd0, h} : {{16{h[15]}}, h};
    end else begin
      r = word;
    end
    return r;
  endfunction

  // funct3 011/110/111 fall through to word along with 010.
  assign is_byte = (funct3[1:0] == 2'b00);
  assign is_half = (funct3[1:0] == 2'b01);

  // Decode the incoming request into size, byte enables and replicated store data.
  always_comb begin
    size_d  = SZ_WORD;
    be_d    = 4'b1111;
    wdata_d = wdata;
    if (is_byte) begin
      size_d  = SZ_BYTE;
      be_d    = 4'b0001 << addr[1:0];
      wdata_d = {4{wdata[7:0]}};
    end else if (is_half) begin
      size_d  = SZ_HALF;
      be_d    = addr[1] ? 4'b1100 : 4'b0011;
      wdata_d = {2{wdata[15:0]}};
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Halfword needs addr[0]==0, word needs addr[1:0]==0; bytes never fault.
  assign trap = (is_half & addr[0]) | (~is_byte & ~is_half & (addr[1:0] != 2'b00));
`else
  // Low address bits are simply dropped for half/word accesses.
  assign trap = 1'b0;
`endif

  assign in_idle   = (state_q == ST_IDLE);
  assign in_access = (state_q == ST_ACCESS);

  // Stall is gated by reset so an abandoned access releases the core at once.
  assign stall = reset & ((in_idle & mem_en & ~trap) | in_access);
  // Timeout fault is registered into DONE; an alignment fault flags the request cycle itself.
  assign err   = err_q | (reset & in_idle & mem_en & trap);
  assign rdata = rdata_q;

  assign mem.bus_req   = bus_req_q;
  assign mem.bus_we    = bus_we_q;
  assign mem.bus_addr  = bus_addr_q;
  assign mem.bus_wdata = bus_wdata_q;
  assign mem.bus_be    = bus_be_q;

  // Access sequencer: latch request in IDLE, hold the bus in ACCESS, report in DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      wait_q      <= 8'd0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      bus_be_q    <= 4'd0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
      req_we_q    <= 1'b0;
      req_size_q  <= SZ_BYTE;
      req_uns_q   <= 1'b0;
      req_off_q   <= 2'd0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mem_en) begin
            if (trap) begin
              rdata_q <= 32'd0;
            end else begin
              state_q     <= ST_ACCESS;
              wait_q      <= 8'd1;
              bus_req_q   <= 1'b1;
              bus_we_q    <= mem_we;
              bus_addr_q  <= {addr[31:2], 2'b00};
              bus_wdata_q <= wdata_d;
              bus_be_q    <= be_d;
              req_we_q    <= mem_we;
              req_size_q  <= size_d;
              req_uns_q   <= funct3[2];
              req_off_q   <= addr[1:0];
            end
          end
        end
        ST_ACCESS: begin
          // Acknowledge wins over a timeout landing on the same cycle.
          if (mem.bus_ack) begin
            state_q   <= ST_DONE;
            wait_q    <= 8'd0;
            bus_req_q <= 1'b0;
            rdata_q   <= req_we_q ? 32'd0
                                  : load_extend(mem.bus_rdata, req_size_q, req_uns_q, req_off_q);
          end else if (wait_q == MAX_WAIT_C) begin
            state_q   <= ST_DONE;
            wait_q    <= 8'd0;
            bus_req_q <= 1'b0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b1;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit -- directed bench for load_store_unit with a
// transaction-level reference model and a per-cycle compare process.
module tb_load_store_unit;

  localparam int MAXW = 16;

  logic        clk;
  logic        reset;
  logic        mem_en;
  logic        mem_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        err;

  load_store_unit_if mem_bus ();

  load_store_unit #(.MAX_WAIT(MAXW)) dut (
    .clk    (clk),
    .reset  (reset),
    .mem_en (mem_en),
    .mem_we (mem_we),
    .funct3 (funct3),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .stall  (stall),
    .err    (err),
    .mem    (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Expectations for the current cycle, written by the stimulus after each rising edge.
  logic        chk_en = 1'b0;
  logic        exp_stall, exp_req, exp_err, exp_we, exp_rd_vld;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [3:0]  exp_be;

  // Observations gathered by the compare process for the literal checks.
  int          stall_hi = 0;
  int          req_hi   = 0;
  int          err_hi   = 0;
  logic [31:0] seen_addr, seen_wdata, done_rdata;
  logic [3:0]  seen_be;
  logic        seen_we;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic m_trap(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    int sz;
    sz = m_size(f3);
    return (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int off;
    off = int'(a[1:0]);
    case (m_size(f3))
      1:       return 4'(1 << off);
      2:       return 4'(3 << (off & 2));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (m_size(f3))
      1:       return {24'd0, wd[7:0]} * 32'h0101_0101;
      2:       return {16'd0, wd[15:0]} * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] brd);
    int off;
    longint v;
    off = int'(a[1:0]);
    case (m_size(f3))
      1: begin
        v = longint'((brd >> (8 * off)) & 32'hFF);
        if (!f3[2] && v > 127) v = v - 256;
      end
      2: begin
        v = longint'((brd >> (8 * (off & 2))) & 32'hFFFF);
        if (!f3[2] && v > 32767) v = v - 65536;
      end
      default: v = longint'(brd);
    endcase
    return 32'(v);
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", 32'(stall), 32'(exp_stall));
      check("bus_req", 32'(mem_bus.bus_req), 32'(exp_req));
      check("err", 32'(err), 32'(exp_err));
      if (exp_req) begin
        check("bus_addr", mem_bus.bus_addr, exp_addr);
        check("bus_be", 32'(mem_bus.bus_be), 32'(exp_be));
        check("bus_we", 32'(mem_bus.bus_we), 32'(exp_we));
        if (exp_we) check("bus_wdata", mem_bus.bus_wdata, exp_wdata);
      end
      if (exp_rd_vld) begin
        check("rdata", rdata, exp_rdata);
        done_rdata = rdata;
      end
      if (stall) stall_hi++;
      if (err) err_hi++;
      if (mem_bus.bus_req) begin
        req_hi++;
        seen_addr  = mem_bus.bus_addr;
        seen_be    = mem_bus.bus_be;
        seen_wdata = mem_bus.bus_wdata;
        seen_we    = mem_bus.bus_we;
      end
    end
  end

  task automatic set_idle_exp();
    exp_stall  = 1'b0;
    exp_req    = 1'b0;
    exp_err    = 1'b0;
    exp_rd_vld = 1'b0;
  endtask

  // One core access; entered and left just after a rising edge. ack_at = ACCESS
  // cycle carrying bus_ack (0 = never).
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] brd, input int ack_at,
                     input logic en_in_done);
    int   k;
    logic fin;
    logic tmo;
    mem_en = 1'b1; mem_we = we; funct3 = f3; addr = a; wdata = wd;
    mem_bus.bus_ack = 1'b0; mem_bus.bus_rdata = 32'h5A5A_5A5A;
    exp_req = 1'b0; exp_rd_vld = 1'b0;
    if (m_trap(f3, a)) begin
      exp_stall = 1'b0; exp_err = 1'b1;
      @(posedge clk); #1;
      mem_en = 1'b0;
      set_idle_exp();
      exp_rd_vld = 1'b1; exp_rdata = 32'd0;
      @(posedge clk); #1;
      set_idle_exp();
      return;
    end
    exp_stall = 1'b1; exp_err = 1'b0;
    @(posedge clk); #1;
    exp_req = 1'b1; exp_we = we; exp_addr = {a[31:2], 2'b00};
    exp_be = m_be(f3, a); exp_wdata = m_wdata(f3, wd);
    // Core inputs change under a stall; the unit must use what it latched.
    addr = ~a; wdata = ~wd; funct3 = 3'b010; mem_we = ~we;
    k = 1; fin = 1'b0; tmo = 1'b0;
    while (!fin) begin
      mem_bus.bus_ack   = (k == ack_at);
      mem_bus.bus_rdata = (k == ack_at) ? brd : ~brd;
      @(posedge clk); #1;
      if (k == ack_at) fin = 1'b1;
      else if (k == MAXW) begin fin = 1'b1; tmo = 1'b1; end
      k++;
    end
    mem_bus.bus_ack = 1'b0;
    mem_en = en_in_done;
    exp_req = 1'b0; exp_stall = 1'b0; exp_err = tmo;
    exp_rd_vld = 1'b1;
    exp_rdata = (tmo || we) ? 32'd0 : m_load(f3, a, brd);
    @(posedge clk); #1;
    mem_en = 1'b0;
    set_idle_exp();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int s_st, s_rq, s_er;

  initial begin
    reset = 1'b0; mem_en = 1'b0; mem_we = 1'b0; funct3 = 3'b000;
    addr = 32'd0; wdata = 32'd0;
    mem_bus.bus_ack = 1'b0; mem_bus.bus_rdata = 32'd0;
    set_idle_exp();
    exp_we = 1'b0; exp_addr = '0; exp_wdata = '0; exp_rdata = '0; exp_be = '0;

    // Reset state
    #3;
    check("rst_rdata", rdata, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_bus_req", 32'(mem_bus.bus_req), 32'd0);
    check("rst_bus_addr", mem_bus.bus_addr, 32'd0);
    check("rst_bus_wdata", mem_bus.bus_wdata, 32'd0);
    check("rst_bus_be", 32'(mem_bus.bus_be), 32'd0);
    check("rst_bus_we", 32'(mem_bus.bus_we), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // LW 0x100, immediate ack
    s_st = stall_hi;
    txn(1'b0, 3'b010, 32'h100, 32'd0, 32'hDEAD_BEEF, 1, 1'b0);
    check("lw_be", 32'(seen_be), 32'hF);
    check("lw_rdata", done_rdata, 32'hDEAD_BEEF);
    check("lw_stall_cycles", 32'(stall_hi - s_st), 32'd2);

    // LB / LBU 0x103
    txn(1'b0, 3'b000, 32'h103, 32'd0, 32'h80FF_FFFF, 1, 1'b0);
    check("lb_be", 32'(seen_be), 32'h8);
    check("lb_rdata", done_rdata, 32'hFFFF_FF80);
    txn(1'b0, 3'b100, 32'h103, 32'd0, 32'h80FF_FFFF, 1, 1'b1);
    check("lbu_rdata", done_rdata, 32'h0000_0080);

    // SH 0x202, ack in third ACCESS cycle
    s_st = stall_hi;
    txn(1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 32'hFFFF_FFFF, 3, 1'b0);
    check("sh_be", 32'(seen_be), 32'hC);
    check("sh_wdata", seen_wdata, 32'hABCD_ABCD);
    check("sh_we", 32'(seen_we), 32'd1);
    check("sh_stall_cycles", 32'(stall_hi - s_st), 32'd4);
    check("sh_rdata", done_rdata, 32'd0);

    // Further patterns checked by the model
    txn(1'b0, 3'b001, 32'h102, 32'd0, 32'h8001_7FFF, 2, 1'b0);
    check("lh_rdata", done_rdata, 32'hFFFF_8001);
    txn(1'b0, 3'b101, 32'h100, 32'd0, 32'h8001_7FFF, 1, 1'b0);
    check("lhu_rdata", done_rdata, 32'h0000_7FFF);
    txn(1'b1, 3'b000, 32'h101, 32'h0000_00A5, 32'd0, 1, 1'b0);
    check("sb_wdata", seen_wdata, 32'hA5A5_A5A5);
    check("sb_be", 32'(seen_be), 32'h2);
    txn(1'b1, 3'b010, 32'h104, 32'h1234_5678, 32'd0, 2, 1'b0);
    txn(1'b0, 3'b011, 32'h108, 32'd0, 32'hCAFE_F00D, 1, 1'b0);
    check("f3_011_word", done_rdata, 32'hCAFE_F00D);
    txn(1'b0, 3'b110, 32'h10C, 32'd0, 32'h0123_4567, 1, 1'b0);
    // Ack arriving exactly on the last allowed wait cycle is not a timeout
    s_er = err_hi;
    txn(1'b0, 3'b010, 32'h110, 32'd0, 32'h7777_0000, MAXW, 1'b0);
    check("ack_at_limit_err", 32'(err_hi - s_er), 32'd0);

    // Timeout
    s_st = stall_hi; s_rq = req_hi; s_er = err_hi;
    txn(1'b0, 3'b010, 32'h300, 32'd0, 32'h1111_2222, 0, 1'b0);
    check("tmo_req_cycles", 32'(req_hi - s_rq), 32'd16);
    check("tmo_err_pulses", 32'(err_hi - s_er), 32'd1);
    check("tmo_rdata", done_rdata, 32'd0);
    check("tmo_stall_cycles", 32'(stall_hi - s_st), 32'd17);

    // Misaligned LW 0x101
    s_rq = req_hi; s_er = err_hi;
    txn(1'b0, 3'b010, 32'h101, 32'd0, 32'h1122_3344, 1, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_err", 32'(err_hi - s_er), 32'd1);
    check("mis_no_req", 32'(req_hi - s_rq), 32'd0);
`else
    check("mis_addr", seen_addr, 32'h100);
    check("mis_be", 32'(seen_be), 32'hF);
    check("mis_no_err", 32'(err_hi - s_er), 32'd0);
    check("mis_rdata", done_rdata, 32'h1122_3344);
`endif

    // Reset during second ACCESS cycle
    chk_en = 1'b0;
    mem_en = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h400;
    mem_bus.bus_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rstmid_req_before", 32'(mem_bus.bus_req), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("rstmid_req", 32'(mem_bus.bus_req), 32'd0);
    check("rstmid_stall", 32'(stall), 32'd0);
    check("rstmid_err", 32'(err), 32'd0);
    check("rstmid_rdata", rdata, 32'd0);
    @(negedge clk);
    mem_en = 1'b0;
    reset = 1'b1;
    #1;
    check("rstrel_stall", 32'(stall), 32'd0);
    // New request presented right after release is taken on the next rising edge
    mem_en = 1'b1; addr = 32'h500;
    @(posedge clk); #1;
    check("rstrel_first_req", 32'(mem_bus.bus_req), 32'd1);
    check("rstrel_addr", mem_bus.bus_addr, 32'h500);
    mem_bus.bus_ack = 1'b1; mem_bus.bus_rdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    mem_bus.bus_ack = 1'b0; mem_en = 1'b0;
    check("rstrel_rdata", rdata, 32'h0BAD_F00D);
    check("rstrel_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    check("rstrel_idle_stall", 32'(stall), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
